cpu_state_dump: RTL
===================

# cpu_state_dump

Post-halt architectural state streamer that sits directly downstream of `cpu`. On a start pulse it snapshots the 15 general registers and the PC, then emits them one 16-bit word per handshake, followed by an XOR checksum word. Benches and on-chip debug logic read final register contents through this port instead of probing `cpu` internals hierarchically, so the stream survives gate-level netlists.

## Interface
- `NREGS`, 15: general registers captured (`MEM[0..NREGS-1]`).
- `W`, 16: register and data width.
- `PC_SHIFT`, 2: right shift applied to the PC before emission (byte address to word index).

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to snapshot and stream.
- `MEM`  in  [NREGS-1:0][W-1:0]  register file contents from `cpu`.
- `PC`  in  W  program counter from `cpu`, byte address.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word on this edge.
- `out_data`  out  W  streamed word.
- `out_idx`  out  5  word index: 0–14 are registers, 15 is the PC, 16 is the checksum.
- `out_last`  out  1  high with the checksum word.
- `busy`  out  1  snapshot held, stream in progress.
- `done`  out  1  stream complete; sticky until the next `start` or `reset`.

## Operation
- States:
  - IDLE: `start` moves to STREAM.
  - STREAM: a transfer with index < 15 increments the index; a transfer at index 15 moves to CSUM.
  - CSUM: a transfer moves to DONE.
  - DONE: `start` moves to STREAM.
- Snapshot:
  - On an edge where `start` is accepted (IDLE or DONE), latch `MEM` and `PC >> PC_SHIFT` (logical shift, zero fill) into internal registers.
  - Clear the index and the checksum accumulator on the same edge.
- Streaming:
  - The stream is driven only from the snapshot.
  - Changes on `MEM`/`PC` after the snapshot have no effect.
- Emitted words:
  - Word k for k=0..14 is `snap[k]`.
  - Word 15 is the shifted PC.
  - Word 16 is the XOR of words 0–15.
- Checksum: the accumulator XORs in each word as it transfers (`out_valid & out_ready`).
- `start` in STREAM or CSUM is ignored; there is no restart mid-stream.
- Status outputs:
  - `busy` = state is STREAM or CSUM.
  - `done` = state is DONE.
  - `out_valid` = `busy`.
- Reset:
  - Returns to IDLE from any state, including mid-stream.
  - Clears snapshot, index and accumulator to 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `start` to any output.
- Start latency: `start` sampled at edge N gives `out_valid`=1 with `out_idx`=0 from edge N onward, i.e. visible in cycle N+1.
- Handshake:
  - A transfer occurs on an edge where `out_valid & out_ready`.
  - While `out_valid & !out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
  - `out_valid` never drops before the checksum transfers.
- Throughput: 1 word per cycle with `out_ready` held high, giving 17 cycles from first valid to `done`.
- Completion: `done` rises in the cycle after the checksum transfer; `out_valid` and `out_last` fall on the same edge.
- Reset and `start` asserted together: reset wins.

## Structure
- `cpu_dump_pkg` holds:
  - the `W`, `NREGS` and `CSUM_IDX`=16 constants;
  - the `dump_state_t` enum {IDLE, STREAM, CSUM, DONE}.
- Single module, no sub-modules.
  - The snapshot is a plain register array.
  - The output word is a mux indexed by `out_idx`.

## Test plan
- Reset mid-stream:
  - Stimulus: assert `reset` at `out_idx`=7.
  - Required: next cycle `out_valid`=0, `busy`=0, `done`=0, `out_idx`=0. A later `start` streams from index 0 with a fresh checksum.
- Full-rate stream:
  - Stimulus: `MEM[k]`=k+1, `PC`=16'h0040, `out_ready`=1, pulse `start`.
  - Required: words 1..15, then 16'h0010, then checksum 16'h0010 (XOR of 1..15 is 0, so the checksum equals the PC word). `out_last` only on idx 16. `done` one cycle after.
- Snapshot isolation:
  - Stimulus: after `start`, change every `MEM[k]` to 16'hFFFF.
  - Required: the stream still carries the original values.
- Backpressure:
  - Stimulus: `out_ready` toggled 1,0,0,1,… throughout.
  - Required: data and index stable during each stall; 17 transfers in order; same checksum as the full-rate case.
- `start` ignored while busy:
  - Stimulus: pulse `start` at `out_idx`=5.
  - Required: the index continues 6,7,…, no re-snapshot.
- Restart from DONE:
  - Stimulus: with `MEM` all 16'hA5A5 and `PC`=0, pulse `start` while `done`=1.
  - Required: `done` clears; 15×16'hA5A5 and 16'h0000, then checksum 16'hA5A5 (odd count).

Source files
------------

// File: rtl/cpu_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_dump_pkg
// Brief    : Shared constants and state type for the CPU state dump streamer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_dump_pkg;

  localparam int W        = 16;  // register / data width
  localparam int NREGS    = 15;  // general registers captured
  localparam int CSUM_IDX = 16;  // word index of the trailing checksum

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2,
    DONE   = 2'd3
  } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_state_dump.sv
`default_nettype none
// ============================================================================
// Module   : cpu_state_dump
// Brief    : Snapshots the register file and PC on start, then streams them
//            one word per valid/ready handshake followed by an XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_state_dump #(
  parameter int NREGS    = cpu_dump_pkg::NREGS,
  parameter int W        = cpu_dump_pkg::W,
  parameter int PC_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NREGS-1:0][W-1:0]   MEM,
  input  logic [W-1:0]              PC,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_data,
  output logic [4:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  import cpu_dump_pkg::*;

  // Index bits needed to address the snapshot array.
  localparam int         c_IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] c_PC_IDX   = 5'(NREGS);
  localparam logic [4:0] c_CSUM_IDX = 5'(NREGS + 1);

  dump_state_t               r_state;
  dump_state_t               w_state_nxt;
  logic [NREGS-1:0][W-1:0]   r_snap;
  logic [W-1:0]              r_pc;
  logic [W-1:0]              r_acc;
  logic [4:0]                r_idx;
  logic [W-1:0]              w_word;
  logic                      w_busy;
  logic                      w_xfer;
  logic                      w_start_ok;

  assign w_busy     = (r_state == STREAM) || (r_state == CSUM);
  assign w_xfer     = w_busy && out_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // Next-state decode; start is only honoured outside of an active stream.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = STREAM;
      STREAM:  if (out_ready && (r_idx == c_PC_IDX)) w_state_nxt = CSUM;
      CSUM:    if (out_ready) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = STREAM;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, snapshot capture, word index and checksum accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_pc    <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_snap <= MEM;
        r_pc   <= PC >> PC_SHIFT;
        r_acc  <= '0;
        r_idx  <= '0;
      end else if (w_xfer) begin
        if (r_state == STREAM) begin
          r_acc <= r_acc ^ w_word;
        end
        if (r_idx != c_CSUM_IDX) begin
          r_idx <= r_idx + 5'd1;
        end
      end
    end
  end

  // Word mux: registers, then shifted PC, then the running checksum.
  always_comb begin
    w_word = '0;
    if (r_idx < c_PC_IDX) begin
      w_word = r_snap[r_idx[c_IW-1:0]];
    end else if (r_idx == c_PC_IDX) begin
      w_word = r_pc;
    end else begin
      w_word = r_acc;
    end
  end

  assign busy      = w_busy;
  assign done      = (r_state == DONE);
  assign out_valid = w_busy;
  assign out_last  = (r_state == CSUM);
  assign out_idx   = r_idx;
  assign out_data  = w_busy ? w_word : '0;

endmodule
`default_nettype wire
